// File: rtl/lfsr_cfg_loader_pkg.sv
// Shared types and constants for the LFSR serial configuration loader.
package lfsr_cfg_loader_pkg;

  localparam int unsigned MAX_PIXEL_BITS = 24;
  localparam int unsigned DONE_TIMEOUT_DEF = 16;

  // Target encoding carried by the first bit of every frame
  localparam logic CFG_SEED = 1'b0;
  localparam logic CFG_STOP = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    COMMIT    = 2'd2,
    WAIT_DONE = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_shift_reg.sv
// Parallel-load / serial-in shift register, MSB shifted out first.
module cfg_shift_reg #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;

  // Load takes priority over shift
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_q <= '0;
    end else if (load_i) begin
      r_q <= load_data_i;
    end else if (shift_i) begin
      r_q <= {r_q[W-2:0], sin_i};
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/lfsr_cfg_loader.sv
// Serial config front-end for the LFSR: deframes target+word, strobes it out, waits for ack.
// Optional readback of the old LFSR value on sdo_o under `LFSR_CFG_READBACK_EN.
module lfsr_cfg_loader
  import lfsr_cfg_loader_pkg::*;
#(
  parameter int unsigned DATA_W       = MAX_PIXEL_BITS,
  parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              sel_n_i,
  input  logic              sdi_i,
  input  logic              sdi_valid_i,
  output logic              config_o,
  output logic              config_rdy_o,
  output logic [DATA_W-1:0] config_data_o,
  input  logic              config_done_i,
  input  logic [DATA_W-1:0] cfg_rd_data_i,
  output logic              sdo_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

  cfg_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_armed, r_config, r_rdy, r_busy, r_err;
  logic [DATA_W-1:0] r_data, w_shift_q;
  logic              w_bit, w_shift_en, w_start, w_last, w_abort, w_ack, w_tmo_hit, w_frame_end;
  logic              w_unused_msb;

  assign w_bit      = ~sel_n_i & sdi_valid_i;
  assign w_shift_en = (r_state == SHIFT) & w_bit;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last      = 1'b0;
    w_abort     = 1'b0;
    w_ack       = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && w_bit) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sel_n_i) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else if (sdi_valid_i && (r_cnt == CNT_W'(DATA_W - 1))) begin
          w_last      = 1'b1;
          w_state_nxt = COMMIT;
        end
      end
      // Ack during the strobe cycle is deliberately not looked at
      COMMIT: w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (config_done_i) begin
          w_ack       = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_tmo == TMO_W'(DONE_TIMEOUT - 1)) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_frame_end = w_abort | w_ack | w_tmo_hit;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_armed  <= 1'b1;
      r_config <= CFG_SEED;
      r_rdy    <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_start)         r_cnt <= '0;
      else if (w_shift_en) r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == COMMIT)         r_tmo <= '0;
      else if (r_state == WAIT_DONE) r_tmo <= r_tmo + TMO_W'(1);

      // A held-low select must be released before another frame may start
      if (w_frame_end)  r_armed <= 1'b0;
      else if (sel_n_i) r_armed <= 1'b1;

      if (w_start) r_config <= sdi_i;

      r_rdy <= w_last;
      if (w_last) r_data <= {w_shift_q[DATA_W-2:0], sdi_i};

      if (w_start)          r_busy <= 1'b1;
      else if (w_frame_end) r_busy <= 1'b0;

      if (w_start)                      r_err <= 1'b0;
      else if (w_abort || w_tmo_hit)    r_err <= 1'b1;
    end
  end

  cfg_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .load_i      (w_start),
    .load_data_i ('0),
    .shift_i     (w_shift_en),
    .sin_i       (sdi_i),
    .q_o         (w_shift_q)
  );

  assign w_unused_msb  = w_shift_q[DATA_W-1];
  assign config_o      = r_config;
  assign config_rdy_o  = r_rdy;
  assign config_data_o = r_data;
  assign busy_o        = r_busy;
  assign err_o         = r_err;

`ifdef LFSR_CFG_READBACK_EN
  logic              r_cap, r_sdo, w_rb_shift, w_unused_rb;
  logic [DATA_W-1:0] w_rb_q;

  // Capture one cycle after the target bit so the LFSR mux reflects the new target;
  // a data bit landing on the capture cycle does not advance the readback.
  assign w_rb_shift = w_shift_en & ~r_cap;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_cap <= 1'b0;
      r_sdo <= 1'b0;
    end else begin
      r_cap <= w_start;
      if (w_state_nxt != SHIFT) r_sdo <= 1'b0;
      else if (r_cap)           r_sdo <= cfg_rd_data_i[DATA_W-1];
      else if (w_rb_shift)      r_sdo <= w_rb_q[DATA_W-2];
    end
  end

  cfg_shift_reg #(.W(DATA_W)) u_rb_sr (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .load_i      (r_cap),
    .load_data_i (cfg_rd_data_i),
    .shift_i     (w_rb_shift),
    .sin_i       (1'b0),
    .q_o         (w_rb_q)
  );

  assign w_unused_rb = ^w_rb_q;
  assign sdo_o       = r_sdo;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^cfg_rd_data_i;
  assign sdo_o       = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_cfg_loader.sv
// Self-checking bench for lfsr_cfg_loader; scoreboard of expected strobed words.
module tb_lfsr_cfg_loader;
  import lfsr_cfg_loader_pkg::*;

  localparam int unsigned DW  = 24;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic          tgt;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          nreset_i, sel_n_i, sdi_i, sdi_valid_i, config_done_i;
  logic [DW-1:0] cfg_rd_data_i, config_data_o;
  logic          config_o, config_rdy_o, sdo_o, busy_o, err_o;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_strobe = 0;
  int   s0;

  always #5 clk_i = ~clk_i;

  lfsr_cfg_loader dut (
    .clk_i         (clk_i),
    .nreset_i      (nreset_i),
    .sel_n_i       (sel_n_i),
    .sdi_i         (sdi_i),
    .sdi_valid_i   (sdi_valid_i),
    .config_o      (config_o),
    .config_rdy_o  (config_rdy_o),
    .config_data_o (config_data_o),
    .config_done_i (config_done_i),
    .cfg_rd_data_i (cfg_rd_data_i),
    .sdo_o         (sdo_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Every strobe must match the oldest outstanding frame
  always @(negedge clk_i) begin
    exp_t e;
    if (nreset_i && config_rdy_o) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(config_rdy_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_target", 32'(config_o), 32'(e.tgt));
        check("sb_data", 32'(config_data_o), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sel_n_i     = 1'b0;
    sdi_i       = b;
    sdi_valid_i = 1'b1;
    tick();
    sdi_valid_i = 1'b0;
    sdi_i       = 1'b0;
  endtask

  // Re-arm, send target + word MSB first with `gap` idle cycles before each data bit
  task automatic send_frame(input logic tgt, input logic [DW-1:0] data, input int gap,
                            input logic chk_rb, input logic [DW-1:0] rb);
    sel_n_i = 1'b1;
    tick();
    send_bit(tgt);
    check("busy_after_target", 32'(busy_o), 32'd1);
    check("err_cleared_at_start", 32'(err_o), 32'd0);
    exp_q.push_back({tgt, data});
    for (int i = DW - 1; i >= 0; i--) begin
      sel_n_i = 1'b0;
      repeat (gap) tick();
`ifdef LFSR_CFG_READBACK_EN
      if (chk_rb) check("sdo_readback", 32'(sdo_o), 32'(rb[i]));
`else
      if (chk_rb) check("sdo_tied_low", 32'(sdo_o), 32'd0);
`endif
      send_bit(data[i]);
    end
  endtask

  task automatic ack_now();
    config_done_i = 1'b1;
    tick();
    config_done_i = 1'b0;
  endtask

  initial begin
    nreset_i      = 1'b0;
    sel_n_i       = 1'b1;
    sdi_i         = 1'b0;
    sdi_valid_i   = 1'b0;
    config_done_i = 1'b0;
    cfg_rd_data_i = '0;
    #12;
    check("rst_config", 32'(config_o), 32'd0);
    check("rst_rdy", 32'(config_rdy_o), 32'd0);
    check("rst_data", 32'(config_data_o), 32'd0);
    check("rst_busy_err_sdo", 32'({busy_o, err_o, sdo_o}), 32'd0);
    nreset_i = 1'b1;
    tick();

    // Seed write, ack on first WAIT_DONE cycle
    send_frame(1'b0, 24'hA5A5A5, 0, 1'b0, '0);
    check("t1_rdy_after_bit25", 32'(config_rdy_o), 32'd1);
    check("t1_config", 32'(config_o), 32'd0);
    check("t1_data", 32'(config_data_o), 32'hA5A5A5);
    tick();
    check("t1_rdy_one_cycle", 32'(config_rdy_o), 32'd0);
    ack_now();
    check("t1_busy_after_ack", 32'(busy_o), 32'd0);
    check("t1_strobes", 32'(n_strobe), 32'd1);

    // Stop write with valid every third cycle
    s0 = n_strobe;
    send_frame(1'b1, 24'h000FFF, 2, 1'b0, '0);
    check("t2_rdy_after_last", 32'(config_rdy_o), 32'd1);
    check("t2_no_early_strobe", 32'(n_strobe), 32'(s0));
    repeat (3) tick();
    ack_now();
    check("t2_busy_after_ack", 32'(busy_o), 32'd0);
    check("t2_strobes", 32'(n_strobe), 32'(s0 + 1));
    check("t2_config", 32'(config_o), 32'd1);

    // Abort after 10 data bits
    s0 = n_strobe;
    sel_n_i = 1'b1;
    tick();
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    sel_n_i = 1'b1;
    tick();
    check("t3_err", 32'(err_o), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    repeat (3) tick();
    check("t3_no_strobe", 32'(n_strobe), 32'(s0));
    check("t3_data_kept", 32'(config_data_o), 32'h000FFF);
    check("t3_err_sticky", 32'(err_o), 32'd1);

    // Timeout; an ack during the strobe cycle is ignored
    send_frame(1'b1, 24'hC3C3C3, 0, 1'b0, '0);
    config_done_i = 1'b1;
    tick();
    config_done_i = 1'b0;
    repeat (TMO - 1) tick();
    check("t4_err_before_timeout", 32'(err_o), 32'd0);
    check("t4_busy_before_timeout", 32'(busy_o), 32'd1);
    tick();
    check("t4_err_at_timeout", 32'(err_o), 32'd1);
    check("t4_busy_at_timeout", 32'(busy_o), 32'd0);

    // Re-arm: a held-low select with bits flowing cannot start a second frame
    send_frame(1'b0, 24'h5A5A5A, 0, 1'b0, '0);
    tick();
    ack_now();
    s0 = n_strobe;
    for (int i = 0; i < 30; i++) send_bit(1'b1);
    check("t5_no_second_strobe", 32'(n_strobe), 32'(s0));
    check("t5_not_busy", 32'(busy_o), 32'd0);
    send_frame(1'b1, 24'h0F0F0F, 0, 1'b0, '0);
    tick();
    ack_now();
    check("t5_strobe_after_rearm", 32'(n_strobe), 32'(s0 + 1));

    // Readback of old value while writing a new seed
    cfg_rd_data_i = 24'h123456;
    send_frame(1'b0, 24'hFFFFFF, 1, 1'b1, 24'h123456);
    check("t6_sdo_low_in_commit", 32'(sdo_o), 32'd0);
    tick();
    ack_now();

    // Reset mid-SHIFT
    sel_n_i = 1'b1;
    tick();
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    s0 = n_strobe;
    nreset_i = 1'b0;
    #2;
    check("t7_rst_config", 32'(config_o), 32'd0);
    check("t7_rst_data", 32'(config_data_o), 32'd0);
    check("t7_rst_flags", 32'({config_rdy_o, busy_o, err_o, sdo_o}), 32'd0);
    tick();
    nreset_i = 1'b1;
    sel_n_i  = 1'b1;
    repeat (30) tick();
    check("t7_no_strobe", 32'(n_strobe), 32'(s0));
    check("t7_idle_busy", 32'(busy_o), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
